data_mem_bridge: RTL and testbench

- Downstream neighbour of the single-cycle datapath. Consumes its data-memory address, store data and load/store strobes, and runs a valid/ready bus transaction to data memory.
- Returns load data on the datapath's read-data input.
- Holds `stall` high while a transaction is outstanding, so the core freezes its PC and register writes until the access completes.

---
 rtl/data_mem_bridge.sv | 162 ++++++++++++++++
 tb/tb_data_mem_bridge.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_bridge
// Purpose  : Turns the core's load/store strobes into a valid/ready data-memory
//            transaction, stalling the core until the access completes.
// Revision : 1.0
// ============================================================================
module data_mem_bridge #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic        byte_acc,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic        stall,
    output logic [31:0] read_data,
    output logic        fault,
    output logic        bus_valid,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        RDATA = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic               byte_q, byte_d;
    logic [1:0]         lane_q, lane_d;
    logic [31:0]        baddr_q, baddr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               fault_q, fault_d;
    logic [7:0]         w_rd_byte;
    logic               w_req;
    logic               w_timeout;

    assign w_req     = req_read | req_write;
    assign w_timeout = (cnt_q == c_TIMEOUT_CNT);
    assign w_rd_byte = bus_rdata[{lane_q, 3'b000} +: 8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            byte_q  <= 1'b0;
            lane_q  <= 2'b00;
            baddr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            byte_q  <= byte_d;
            lane_q  <= lane_d;
            baddr_q <= baddr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        byte_d  = byte_q;
        lane_d  = lane_q;
        baddr_d = baddr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: begin
                if (w_req) begin
                    // A simultaneous read+write is issued as the write.
                    wr_d    = req_write;
                    byte_d  = byte_acc;
                    lane_d  = addr[1:0];
                    baddr_d = {addr[31:2], 2'b00};
                    wdata_d = byte_acc ? {4{write_data[7:0]}} : write_data;
                    if (!req_write)
                        wstrb_d = 4'b0000;
                    else if (byte_acc)
                        wstrb_d = 4'b0001 << addr[1:0];
                    else
                        wstrb_d = 4'hF;
                    cnt_d   = '0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (bus_ready) begin
                    cnt_d   = '0;
                    state_d = wr_q ? DONE : RDATA;
                end else if (w_timeout) begin
                    fault_d = 1'b1;
                    if (!wr_q)
                        rdata_d = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RDATA: begin
                if (bus_rvalid) begin
                    rdata_d = byte_q ? {24'd0, w_rd_byte} : bus_rdata;
                    state_d = DONE;
                end else if (w_timeout) begin
                    fault_d = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stall covers the request cycle itself so the core never advances
    // past an instruction whose access has not yet been issued.
    assign stall     = (state_q == ADDR) || (state_q == RDATA) ||
                       ((state_q == IDLE) && w_req);
    assign bus_valid = (state_q == ADDR);
    assign bus_write = wr_q;
    assign bus_addr  = baddr_q;
    assign bus_wdata = wdata_q;
    assign bus_wstrb = wstrb_q;
    assign read_data = rdata_q;
    assign fault     = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_bridge
// Purpose  : Scoreboard bench for data_mem_bridge with a small bus slave model.
// Revision : 1.0
// ============================================================================
module tb_data_mem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_read, req_write, byte_acc;
    logic [31:0] addr, write_data;
    logic        stall, fault, bus_valid, bus_write;
    logic [31:0] read_data, bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ready, bus_rvalid;

    int total = 0;
    int bad   = 0;

    int          ready_dly  = 0;
    int          rvalid_dly = 0;
    logic [31:0] rdata_val  = '0;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [3:0]  strb;
        logic [31:0] wd;
    } req_t;

    typedef struct {
        int          stalls;
        int          valids;
        logic [31:0] rd;
        logic        flt;
    } cmp_t;

    req_t req_q[$];
    cmp_t cmp_q[$];

    data_mem_bridge #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_read   (req_read),
        .req_write  (req_write),
        .byte_acc   (byte_acc),
        .addr       (addr),
        .write_data (write_data),
        .stall      (stall),
        .read_data  (read_data),
        .fault      (fault),
        .bus_valid  (bus_valid),
        .bus_write  (bus_write),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wstrb  (bus_wstrb),
        .bus_ready  (bus_ready),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Slave: ready after ready_dly wait cycles, rvalid rvalid_dly cycles
    // after the read is accepted; junk rvalid is driven while ready is withheld.
    initial begin : slave
        int  vc;
        int  rc;
        logic in_r;
        vc = 0; rc = 0; in_r = 1'b0;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus_ready  = 1'b0;
            bus_rvalid = 1'b0;
            if (reset || !stall) begin
                vc = 0; in_r = 1'b0;
            end else if (bus_valid) begin
                if (vc == ready_dly) begin
                    bus_ready = 1'b1;
                    in_r = !bus_write;
                    rc = 0; vc = 0;
                end else begin
                    vc++;
                    bus_rvalid = 1'b1;
                    bus_rdata  = 32'hBAD0BAD0;
                end
            end else if (in_r) begin
                if (rc == rvalid_dly) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = rdata_val;
                    in_r = 1'b0;
                end else begin
                    rc++;
                end
            end
        end
    end

    initial begin : monitor
        int   sc;
        int   vcnt;
        logic pv;
        req_t cur;
        cmp_t c;
        sc = 0; vcnt = 0; pv = 1'b0;
        cur = '{wr: 1'b0, a: '0, strb: '0, wd: '0};
        forever begin
            @(negedge clk);
            if (reset) begin
                sc = 0; vcnt = 0; pv = 1'b0;
            end else begin
                if (bus_valid) begin
                    if (!pv) begin
                        if (req_q.size() == 0) begin
                            total++; bad++;
                            $display("FAIL unexpected_request: got addr %h expected none", bus_addr);
                        end else begin
                            cur = req_q.pop_front();
                        end
                    end
                    chk("bus_write", {31'd0, bus_write}, {31'd0, cur.wr});
                    chk("bus_addr", bus_addr, cur.a);
                    chk("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, cur.strb});
                    if (cur.wr)
                        chk("bus_wdata", bus_wdata, cur.wd);
                    vcnt++;
                end
                pv = bus_valid;
                if (stall) begin
                    sc++;
                end else if (sc > 0) begin
                    if (cmp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_completion: got %0d stall cycles expected none", sc);
                    end else begin
                        c = cmp_q.pop_front();
                        chk("stall_cycles", 32'(sc), 32'(c.stalls));
                        chk("valid_cycles", 32'(vcnt), 32'(c.valids));
                        chk("read_data", read_data, c.rd);
                        chk("fault", {31'd0, fault}, {31'd0, c.flt});
                    end
                    sc = 0; vcnt = 0;
                end
            end
        end
    end

    // Called at posedge+1 in an IDLE cycle; returns at posedge+1 after DONE.
    task automatic access(input logic rd, input logic wr, input logic bt,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int rdly, input int vdly, input logic [31:0] rdat,
                          input logic [31:0] e_addr, input logic [3:0] e_strb,
                          input logic [31:0] e_wd, input int e_stall, input int e_valid,
                          input logic [31:0] e_rd, input logic e_flt);
        int n;
        req_q.push_back('{wr: wr, a: e_addr, strb: e_strb, wd: e_wd});
        cmp_q.push_back('{stalls: e_stall, valids: e_valid, rd: e_rd, flt: e_flt});
        ready_dly  = rdly;
        rvalid_dly = vdly;
        rdata_val  = rdat;
        req_read   = rd;
        req_write  = wr;
        byte_acc   = bt;
        addr       = a;
        write_data = wd;
        n = 0;
        @(negedge clk);
        while (stall && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            total++; bad++;
            $display("FAIL access_timeout: got stall stuck expected DONE within 60 cycles");
        end
        @(posedge clk);
        #1;
        req_read  = 1'b0;
        req_write = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset = 1'b1;
        req_read = 1'b0; req_write = 1'b0; byte_acc = 1'b0;
        addr = '0; write_data = '0;
        #12;
        chk("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
        chk("rst_bus_write", {31'd0, bus_write}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // rd wr bt addr wdata rdly vdly rdata | e_addr e_strb e_wd stalls valids rd flt
        access(1, 0, 0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF,
               32'h100, 4'h0, 32'h0, 3, 1, 32'hDEADBEEF, 0);
        access(0, 1, 1, 32'h203, 32'h123456AB, 2, 0, 32'h0,
               32'h200, 4'b1000, 32'hABABABAB, 4, 3, 32'hDEADBEEF, 0);
        access(1, 0, 1, 32'h302, 32'h0, 0, 3, 32'h11C23344,
               32'h300, 4'h0, 32'h0, 6, 1, 32'h000000C2, 0);
        access(1, 0, 0, 32'h44, 32'h0, 1, 0, 32'h55AA1234,
               32'h44, 4'h0, 32'h0, 4, 2, 32'h55AA1234, 0);
        access(0, 1, 0, 32'h12, 32'hCAFEF00D, 0, 0, 32'h0,
               32'h10, 4'hF, 32'hCAFEF00D, 2, 1, 32'h55AA1234, 0);
        // Simultaneous read+write, then a load in the very next IDLE cycle.
        access(1, 1, 0, 32'h80, 32'h01020304, 0, 0, 32'h0,
               32'h80, 4'hF, 32'h01020304, 2, 1, 32'h55AA1234, 0);
        access(1, 0, 0, 32'h84, 32'h0, 0, 0, 32'h89ABCDEF,
               32'h84, 4'h0, 32'h0, 3, 1, 32'h89ABCDEF, 0);
        // Slave never ready: five ADDR cycles with TIMEOUT=4, then sticky fault.
        access(1, 0, 0, 32'h40, 32'h0, 255, 0, 32'h0,
               32'h40, 4'h0, 32'h0, 6, 5, 32'h0, 1);
        access(0, 1, 0, 32'h48, 32'h77777777, 0, 0, 32'h0,
               32'h48, 4'hF, 32'h77777777, 2, 1, 32'h0, 1);
        access(1, 0, 1, 32'h301, 32'h0, 0, 0, 32'h11C23344,
               32'h300, 4'h0, 32'h0, 3, 1, 32'h00000033, 1);

        // Reset while waiting in RDATA.
        req_q.push_back('{wr: 1'b0, a: 32'h200, strb: 4'h0, wd: 32'h0});
        ready_dly = 0; rvalid_dly = 50; rdata_val = 32'h0;
        req_read = 1'b1; byte_acc = 1'b0; addr = 32'h200;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_read = 1'b0;
        @(posedge clk); #1;
        chk("rdata_wait_stall", {31'd0, stall}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_bus_valid", {31'd0, bus_valid}, 32'd0);
        chk("abort_stall", {31'd0, stall}, 32'd0);
        chk("abort_read_data", read_data, 32'd0);
        chk("abort_fault", {31'd0, fault}, 32'd0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        access(1, 0, 0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF,
               32'h100, 4'h0, 32'h0, 3, 1, 32'hDEADBEEF, 0);

        repeat (3) @(posedge clk);
        chk("req_queue_empty", 32'(req_q.size()), 32'd0);
        chk("cmp_queue_empty", 32'(cmp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
